// File: rtl/fetch_32.sv
// fetch_32 -- instruction fetch unit for the 32-bit core.
//
// Generates the fetch PC and reads instruction words over a request/acknowledge
// handshake. Each word is buffered with its PC in a 2-entry prefetch queue, and
// the pair is presented to decode. Relative and absolute redirects flush the queue.
// A redirect that arrives while a request is still unacknowledged parks in FLUSH.
// The request stays as issued until its ack, and that word is then dropped.
//
// Ports
//   clk_in, reset_in          clock; asynchronous active-high reset
//   stall_in                  decode stall: output stage holds, nothing popped
//   pc_change_rel_in          relative redirect: pc_base_in + sext(imm_in)
//   pc_change_abs_in          absolute redirect: abs_addr_in (wins over relative)
//   pc_base_in, imm_in        relative redirect base and signed byte offset
//   abs_addr_in               absolute redirect target
//   mem_req_out/mem_addr_out  read request and word-aligned address
//   mem_ack_in/mem_data_in    request accepted; data valid in the same cycle
//   insn_out/insn_pc_out      instruction to decode and its address
//   insn_valid_out            insn_out is a real fetched instruction
module fetch_32 #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INSN = 32'h0000_0000
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        stall_in,
   input  logic        pc_change_rel_in,
   input  logic        pc_change_abs_in,
   input  logic [31:0] pc_base_in,
   input  logic [20:0] imm_in,
   input  logic [31:0] abs_addr_in,
   output logic        mem_req_out,
   output logic [31:0] mem_addr_out,
   input  logic        mem_ack_in,
   input  logic [31:0] mem_data_in,
   output logic [31:0] insn_out,
   output logic [31:0] insn_pc_out,
   output logic        insn_valid_out
);

   typedef enum logic [1:0] {FETCH, HOLD, FLUSH} state_t;

   state_t      state, state_next;
   logic        req, req_next;
   logic [31:0] fetch_pc, fetch_pc_next;
   logic [31:0] flush_pc, flush_pc_next;
   logic [1:0]  count, count_next;
   logic [1:0]  fill;
   logic [31:0] q_insn [2];
   logic [31:0] q_pc   [2];

   logic        redirect;
   logic        acked;
   logic        outstanding;
   logic        push;
   logic        pop;
   logic [31:0] redirect_pc;

   assign redirect    = pc_change_abs_in | pc_change_rel_in;
   assign acked       = req & mem_ack_in;
   assign outstanding = req & ~mem_ack_in;
   // A word acked during a redirect, or while flushing, belongs to the old stream.
   assign push        = acked & (state != FLUSH) & ~redirect;
   assign pop         = ~redirect & ~stall_in & (count != 2'd0);
   // Slot the incoming word lands in, after any pop this cycle has shifted the queue.
   assign fill        = count - {1'b0, pop};

   always_comb begin
      // NOTE: every output of this block gets a default first so no path infers a latch.
      redirect_pc = pc_base_in + {{11{imm_in[20]}}, imm_in};
      if (pc_change_abs_in) begin
         redirect_pc = abs_addr_in;
      end
      redirect_pc[1:0] = 2'b00;
   end

   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      flush_pc_next = flush_pc;
      count_next    = count + {1'b0, push} - {1'b0, pop};
      if (redirect) begin
         count_next = 2'd0;
      end

      unique case (state)
         FETCH, HOLD: begin
            if (acked) begin
               fetch_pc_next = fetch_pc + 32'd4;
            end
            if (redirect && outstanding) begin
               // The request on the bus must not change until acked: park the target.
               state_next    = FLUSH;
               flush_pc_next = redirect_pc;
            end else begin
               if (redirect) begin
                  fetch_pc_next = redirect_pc;
               end
               state_next = (count_next == 2'd2) ? HOLD : FETCH;
            end
         end
         FLUSH: begin
            if (redirect) begin
               flush_pc_next = redirect_pc;
            end
            if (acked) begin
               fetch_pc_next = redirect ? redirect_pc : flush_pc;
               state_next    = FETCH;
            end
         end
         default: state_next = FETCH;
      endcase

      // Request whenever not parked on a full queue; FLUSH keeps the old request up.
      req_next = (state_next != HOLD);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         state    <= FETCH;
         req      <= 1'b0;
         fetch_pc <= RESET_PC;
         flush_pc <= RESET_PC;
         count    <= 2'd0;
      end else begin
         state    <= state_next;
         req      <= req_next;
         fetch_pc <= fetch_pc_next;
         flush_pc <= flush_pc_next;
         count    <= count_next;
      end
   end

   // NOTE: queue payload has no reset; the occupancy count alone decides what is valid.
   always_ff @(posedge clk_in) begin
      if (pop) begin
         q_insn[0] <= q_insn[1];
         q_pc[0]   <= q_pc[1];
      end
      if (push) begin
         if (fill == 2'd0) begin
            q_insn[0] <= mem_data_in;
            q_pc[0]   <= fetch_pc;
         end else begin
            q_insn[1] <= mem_data_in;
            q_pc[1]   <= fetch_pc;
         end
      end
   end

   // Output stage: pops only from the queue (no bypass), so an ack at edge k
   // reaches decode at edge k+1 at the earliest.
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         insn_out       <= NOP_INSN;
         insn_pc_out    <= 32'h0;
         insn_valid_out <= 1'b0;
      end else if (redirect) begin
         insn_out       <= NOP_INSN;
         insn_valid_out <= 1'b0;
      end else if (!stall_in) begin
         if (count != 2'd0) begin
            insn_out       <= q_insn[0];
            insn_pc_out    <= q_pc[0];
            insn_valid_out <= 1'b1;
         end else begin
            insn_out       <= NOP_INSN;
            insn_valid_out <= 1'b0;
         end
      end
   end

   assign mem_req_out  = req;
   assign mem_addr_out = fetch_pc;

endmodule

// File: tb/tb_fetch_32.sv
// tb_fetch_32 -- self-checking bench for fetch_32.
//
// A behavioural memory answers requests with data = address ^ KEY. Every
// acknowledged word that decode should see is pushed to a scoreboard queue.
// The queue is popped and compared whenever the output stage should advance.
// Redirect targets come from a constant vector table.
module tb_fetch_32;

   localparam logic [31:0] KEY = 32'hA5A5_0000;

   logic        clk_in = 1'b0;
   logic        reset_in = 1'b1;
   logic        stall_in = 1'b0;
   logic        pc_change_rel_in = 1'b0;
   logic        pc_change_abs_in = 1'b0;
   logic [31:0] pc_base_in = 32'h0;
   logic [20:0] imm_in = 21'h0;
   logic [31:0] abs_addr_in = 32'h0;
   logic        mem_req_out;
   logic [31:0] mem_addr_out;
   logic        mem_ack_in = 1'b0;
   logic [31:0] mem_data_in = 32'h0;
   logic [31:0] insn_out;
   logic [31:0] insn_pc_out;
   logic        insn_valid_out;

   fetch_32 dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .stall_in         (stall_in),
      .pc_change_rel_in (pc_change_rel_in),
      .pc_change_abs_in (pc_change_abs_in),
      .pc_base_in       (pc_base_in),
      .imm_in           (imm_in),
      .abs_addr_in      (abs_addr_in),
      .mem_req_out      (mem_req_out),
      .mem_addr_out     (mem_addr_out),
      .mem_ack_in       (mem_ack_in),
      .mem_data_in      (mem_data_in),
      .insn_out         (insn_out),
      .insn_pc_out      (insn_pc_out),
      .insn_valid_out   (insn_valid_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } entry_t;

   typedef struct {
      logic        abs_set;
      logic        rel_set;
      logic [31:0] base;
      logic [20:0] imm;
      logic [31:0] abs_addr;
      logic [31:0] target;
   } redir_vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          n_acks = 0;
   int          ack_mode = 0;  // 0 never, 1 every cycle, 2 every third cycle
   entry_t      exp_q[$];
   logic [31:0] exp_fetch = 32'h0;
   logic [31:0] exp_insn = 32'h0;
   logic [31:0] exp_pc = 32'h0;
   logic        exp_valid = 1'b0;
   logic        flushing = 1'b0;
   logic [31:0] flush_target = 32'h0;
   logic [31:0] redir_target = 32'h0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      exp_fetch = 32'h0;
      exp_insn  = 32'h0;
      exp_pc    = 32'h0;
      exp_valid = 1'b0;
      flushing  = 1'b0;
   endtask

   // One clock: drive the memory response, advance the model, then compare.
   task automatic step();
      logic        acked;
      logic        redir;
      logic        prev_req;
      logic [31:0] prev_addr;
      entry_t      e;
      mem_ack_in  = mem_req_out && ((ack_mode == 1) || (ack_mode == 2 && (cyc % 3) == 2));
      mem_data_in = mem_ack_in ? (mem_addr_out ^ KEY) : 32'hDEAD_BEEF;
      acked     = mem_req_out & mem_ack_in;
      redir     = pc_change_abs_in | pc_change_rel_in;
      prev_req  = mem_req_out;
      prev_addr = mem_addr_out;

      // Output stage sees the queue as it was before this edge's push.
      if (redir) begin
         exp_q.delete();
         exp_insn  = 32'h0;
         exp_valid = 1'b0;
      end else if (!stall_in) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            exp_insn  = e.insn;
            exp_pc    = e.pc;
            exp_valid = 1'b1;
         end else begin
            exp_insn  = 32'h0;
            exp_valid = 1'b0;
         end
      end
      if (acked) begin
         n_acks++;
         if (!flushing && !redir) exp_q.push_back(entry_t'{pc: prev_addr, insn: prev_addr ^ KEY});
         if (flushing) begin
            flushing  = 1'b0;
            exp_fetch = flush_target;
         end else begin
            exp_fetch = prev_addr + 32'd4;
         end
      end
      if (redir) begin
         if (prev_req && !acked) begin
            flushing     = 1'b1;
            flush_target = redir_target;
         end else begin
            exp_fetch = redir_target;
         end
      end

      @(posedge clk_in);
      @(negedge clk_in);
      cyc++;
      mem_ack_in = 1'b0;

      check("insn_valid", insn_valid_out, exp_valid);
      check("insn", insn_out, exp_insn);
      check("insn_pc", insn_pc_out, exp_pc);
      check("queue_le2", exp_q.size() <= 2, 1);
      if (prev_req && !acked) begin
         check("req_stable", mem_req_out, 1);
         check("addr_stable", mem_addr_out, prev_addr);
      end
      if (mem_req_out) check("mem_addr", mem_addr_out, exp_fetch);
   endtask

   task automatic redirect(input logic a, input logic r, input logic [31:0] base,
                           input logic [20:0] imm, input logic [31:0] aaddr,
                           input logic [31:0] tgt);
      pc_change_abs_in = a;
      pc_change_rel_in = r;
      pc_base_in       = base;
      imm_in           = imm;
      abs_addr_in      = aaddr;
      redir_target     = tgt;
      step();
      pc_change_abs_in = 1'b0;
      pc_change_rel_in = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"}, mem_req_out, 0);
      check({tag, "_addr"}, mem_addr_out, 32'h0);
      check({tag, "_insn"}, insn_out, 32'h0);
      check({tag, "_insn_pc"}, insn_pc_out, 32'h0);
      check({tag, "_valid"}, insn_valid_out, 0);
   endtask

   task automatic apply_reset();
      reset_in = 1'b1;
      stall_in = 1'b0;
      ack_mode = 0;
      model_clear();
      repeat (2) @(negedge clk_in);
      check_reset_values("reset");
      reset_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
      $fatal(1, "watchdog expired");
   end

   initial begin
      redir_vec_t vecs[5];
      int         base_acks;
      vecs[0] = '{1'b0, 1'b1, 32'h0000_0040, 21'h1F_FFF0, 32'h0,         32'h0000_0030};
      vecs[1] = '{1'b1, 1'b0, 32'h0,         21'h0,       32'h0000_1003, 32'h0000_1000};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0040, 21'h00_0010, 32'h0000_2000, 32'h0000_2000};
      vecs[3] = '{1'b0, 1'b1, 32'h0000_0200, 21'h00_0107, 32'h0,         32'h0000_0304};
      vecs[4] = '{1'b0, 1'b1, 32'h0010_0000, 21'h10_0000, 32'h0,         32'h0000_0000};

      // Reset, then streaming from address 0.
      apply_reset();
      ack_mode = 1;
      step();
      check("first_req", mem_req_out, 1);
      step();
      step();
      check("first_insn", insn_out, 32'hA5A5_0000);
      check("first_insn_pc", insn_pc_out, 32'h0);
      repeat (4) step();

      // Stall while streaming: queue fills, request drops, outputs freeze.
      stall_in  = 1'b1;
      base_acks = n_acks;
      repeat (5) step();
      check("stall_extra_acks_le2", (n_acks - base_acks) <= 2, 1);
      check("hold_req_low", mem_req_out, 0);
      stall_in = 1'b0;
      repeat (5) step();

      // Slow memory: ack every third cycle.
      ack_mode = 2;
      repeat (12) step();
      ack_mode = 1;
      repeat (3) step();

      // Redirect target table, each applied while streaming.
      for (int i = 0; i < 5; i++) begin
         redirect(vecs[i].abs_set, vecs[i].rel_set, vecs[i].base, vecs[i].imm,
                  vecs[i].abs_addr, vecs[i].target);
         check($sformatf("redir_target_%0d", i), mem_addr_out, vecs[i].target);
         repeat (3) step();
      end

      // Redirect while the request to 0x8 is pending.
      apply_reset();
      ack_mode = 1;
      repeat (3) step();
      ack_mode = 0;
      step();
      check("pending_addr", mem_addr_out, 32'h8);
      redirect(1'b1, 1'b0, 32'h0, 21'h0, 32'h0000_1003, 32'h0000_1000);
      repeat (2) step();
      check("flush_hold_addr", mem_addr_out, 32'h8);
      ack_mode = 1;
      step();
      check("flush_new_addr", mem_addr_out, 32'h0000_1000);
      repeat (4) step();

      // Second redirect during FLUSH replaces the parked target.
      ack_mode = 0;
      redirect(1'b1, 1'b0, 32'h0, 21'h0, 32'h0000_3000, 32'h0000_3000);
      redirect(1'b1, 1'b0, 32'h0, 21'h0, 32'h0000_5004, 32'h0000_5004);
      ack_mode = 1;
      step();
      check("flush_replace_addr", mem_addr_out, 32'h0000_5004);
      repeat (3) step();

      // Wrap past the top of the address space.
      redirect(1'b1, 1'b0, 32'h0, 21'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
      check("wrap_top", mem_addr_out, 32'hFFFF_FFFC);
      step();
      check("wrap_zero", mem_addr_out, 32'h0);
      repeat (3) step();

      // Asynchronous reset in the middle of a pending request.
      ack_mode = 0;
      step();
      check("pre_reset_req", mem_req_out, 1);
      reset_in = 1'b1;
      #1;
      check_reset_values("async_reset");
      model_clear();
      @(negedge clk_in);
      reset_in = 1'b0;
      ack_mode = 1;
      repeat (4) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_32.md
# fetch_32

Instruction fetch unit for the 32-bit core. It generates the instruction PC, fetches words from instruction memory over a request/acknowledge handshake, and buffers them in a 2-entry prefetch queue. It presents `insn`/`insn_pc` pairs to `decode_32`, honours the decode stall, and redirects on relative or absolute PC changes.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INSN`, 32'h0000_0000, word driven on `insn_out` when no valid instruction is available

Ports:
- `clk_in`  in  1  clock; all state updates on the rising edge
- `reset_in`  in  1  asynchronous, active-high reset
- `stall_in`  in  1  decode stall; output stage holds its value
- `pc_change_rel_in`  in  1  relative redirect request
- `pc_change_abs_in`  in  1  absolute redirect request
- `pc_base_in`  in  32  PC of the branching instruction (relative base)
- `imm_in`  in  21  signed byte offset for a relative redirect
- `abs_addr_in`  in  32  absolute redirect target
- `mem_req_out`  out  1  memory read request
- `mem_addr_out`  out  32  memory read address, word aligned
- `mem_ack_in`  in  1  memory accepted the request; `mem_data_in` is valid in the same cycle
- `mem_data_in`  in  32  instruction word
- `insn_out`  out  32  instruction to decode
- `insn_pc_out`  out  32  address of `insn_out`
- `insn_valid_out`  out  1  `insn_out` is a real fetched instruction

## Operation
- **Fetch FSM** has three states:
  - FETCH: `mem_req_out` is asserted while queue occupancy after this cycle's pop/push is below 2.
  - HOLD: the queue is full; the request is deasserted. Return to FETCH when a pop frees a slot.
  - FLUSH: a redirect arrived while a request was outstanding.
- **Request completion:** a request completes on an edge where `mem_req_out & mem_ack_in`. The word and `fetch_pc` are pushed to the queue, and `fetch_pc` increments by 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0).
- **Outstanding requests:** at most one request is outstanding. While it is unacknowledged, `mem_req_out` and `mem_addr_out` must stay stable. A request is never withdrawn except by reset.
- **Redirect target:**
  - If `pc_change_abs_in` is set, the target is `abs_addr_in`. Absolute has priority when both redirect inputs are set.
  - Otherwise, if `pc_change_rel_in` is set, the target is `pc_base_in + sign_extend(imm_in)`.
  - Bits [1:0] of the target are forced to 0 in both cases.
- **Redirect handling:**
  - The queue is emptied, `fetch_pc` is set to the target, and `insn_valid_out` becomes 0 with `insn_out = NOP_INSN`. Redirect overrides `stall_in`.
  - If no request is outstanding, or one is acked in the redirect cycle, the acked data is discarded and the next request goes to the target.
  - If a request is outstanding and unacked, go to FLUSH. The address is held until the ack, the data is discarded, then go to FETCH at the target.
  - A second redirect during FLUSH replaces the target.
- **Output stage when `stall_in` = 0:**
  - If the queue is not empty, pop into `insn_out`/`insn_pc_out` and set `insn_valid_out` = 1.
  - If the queue is empty, drive `NOP_INSN` with `insn_valid_out` = 0. `insn_pc_out` holds its value.
- **Output stage when `stall_in` = 1:** all outputs hold and nothing is popped.

## Timing
- **Reset values:**
  - `mem_req_out`=0, `mem_addr_out`=`RESET_PC`, `fetch_pc`=`RESET_PC`
  - `insn_out`=`NOP_INSN`, `insn_pc_out`=0, `insn_valid_out`=0
  - Queue empty, FSM in FETCH.
- `mem_req_out` rises in the first cycle after `reset_in` deasserts.
- **Latency:** a word acked at edge k appears on `insn_out` after edge k+1, when unstalled. There is no bypass.
- **Throughput:** with `mem_ack_in` held high and no stall, one instruction per cycle.
- **Simultaneous push and pop on a full queue:** allowed; occupancy stays 2.
- **Reset asserted mid-handshake:** the outputs return to their reset values immediately (asynchronously) and the request is abandoned.

## Test plan
- **Reset, then streaming:** release reset with `mem_ack_in`=1 and data = address ^ 32'hA5A5_0000.
  - Required: `mem_addr_out` sequence 0,4,8…
  - Required: `insn_out` is 32'hA5A5_0000 with `insn_pc_out`=0, two edges after the first ack, then one instruction per cycle.
- **Stall fills queue:** hold `stall_in`=1 for 5 cycles while streaming.
  - Required: at most 2 extra acks occur, then `mem_req_out`=0 (HOLD) and outputs are frozen.
  - Required: on release, PCs continue contiguous with no drop or duplicate.
- **Slow memory:** ack every 3rd cycle.
  - Required: address stable between acks.
  - Required: `insn_valid_out`=0 with `insn_out`=`NOP_INSN` in empty cycles.
- **Relative redirect:** `pc_base_in`=32'h40, `imm_in`=21'h1F_FFF0 (−16).
  - Required: queue flushed, next request at 32'h30, and no instruction from the old stream appears on the output.
- **Redirect during an unacked request:**
  - Pulse `pc_change_abs_in` with `abs_addr_in`=32'h1003 while the request to 32'h8 is pending.
  - Required: 32'h8 is held until ack and its data discarded, then the request goes to 32'h1000.
  - Required: with both redirect inputs set, the absolute target wins.
- **Wrap and async reset:**
  - Redirect to 32'hFFFF_FFFC. Required: the following request address is 0.
  - Assert `reset_in` mid-request. Required: `mem_req_out`=0 before the next clock edge.
